// File: rtl/myproject_mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// myproject_mul_arb_pkg
// Shared widths and helpers for the round-robin arbitrated 16s x 10s multiplier.
//   A_W   : multiplicand width (signed)
//   B_W   : multiplier width (signed)
//   P_W   : full-precision product width
//   clog2 : ceiling log2, used to size requester indices
// -----------------------------------------------------------------------------
package myproject_mul_arb_pkg;

  localparam int A_W = 16;
  localparam int B_W = 10;
  localparam int P_W = 26;

  typedef logic signed [A_W-1:0] opa_t;
  typedef logic signed [B_W-1:0] opb_t;
  typedef logic signed [P_W-1:0] prod_t;

  // Smallest r with 2**r >= value; values of 0 or 1 give 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < value) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_mul_arb_if.sv
// -----------------------------------------------------------------------------
// myproject_mul_arb_if
// Requester / consumer bus of the arbitrated multiplier.
//   req_vld [NUM_REQ]      : per-requester operand valid
//   req_rdy [NUM_REQ]      : per-requester accept (one-hot or zero)
//   req_a   [NUM_REQ*A_W]  : packed signed multiplicands, requester i at [A_W*i +: A_W]
//   req_b   [NUM_REQ*B_W]  : packed signed multipliers,  requester i at [B_W*i +: B_W]
//   rsp_vld                : result valid
//   rsp_rdy                : consumer accept
//   rsp_id  [ID_W]         : index of the requester owning the result
//   rsp_p   [P_W]          : signed full-precision product
// Modports: master = requesters + consumer, slave = the multiplier block.
// -----------------------------------------------------------------------------
interface myproject_mul_arb_if
  import myproject_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     req_vld;
  logic [NUM_REQ-1:0]     req_rdy;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_vld;
  logic                   rsp_rdy;
  logic [ID_W-1:0]        rsp_id;
  logic [P_W-1:0]         rsp_p;

  modport master (
    output req_vld, req_a, req_b, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_id, rsp_p
  );

  modport slave (
    input  req_vld, req_a, req_b, rsp_rdy,
    output req_rdy, rsp_vld, rsp_id, rsp_p
  );

endinterface

// File: rtl/myproject_mul_arb_16s_10s_mul.sv
// -----------------------------------------------------------------------------
// myproject_mul_mul_16s_10s_26_1_1
// Purely combinational signed multiplier, 16s x 10s -> 26s, full precision.
//   din0 [din0_WIDTH] : signed multiplicand
//   din1 [din1_WIDTH] : signed multiplier
//   dout [dout_WIDTH] : signed product
// -----------------------------------------------------------------------------
module myproject_mul_mul_16s_10s_26_1_1 #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 26
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  logic signed [dout_WIDTH-1:0] a_ext_s;
  logic signed [dout_WIDTH-1:0] b_ext_s;

  // Sign-extend both operands to the product width; the low dout_WIDTH bits
  // of the product are then the exact two's-complement result.
  assign a_ext_s = {{(dout_WIDTH-din0_WIDTH){din0[din0_WIDTH-1]}}, din0};
  assign b_ext_s = {{(dout_WIDTH-din1_WIDTH){din1[din1_WIDTH-1]}}, din1};
  assign dout    = a_ext_s * b_ext_s;

endmodule

// File: rtl/myproject_mul_arb_16s_10s.sv
// -----------------------------------------------------------------------------
// myproject_mul_arb_16s_10s
// NUM_REQ requesters share one pipelined 16s x 10s multiplier through a
// round-robin arbiter. Results return in acceptance order, tagged with the
// requester index, through a valid/ready output with full back-pressure.
//
// Ports:
//   ap_clk        : clock, rising edge
//   ap_rst        : asynchronous active-high reset
//   bus (slave)   : requester/consumer bus, see myproject_mul_arb_if
//   perf_busy_cnt : 32-bit count of operand-transfer cycles (optional)
//
// Parameters:
//   NUM_REQ   : requesters, 2..8
//   NUM_STAGE : accept-to-result latency in cycles, 1..4
//
// Build option:
//   MYPROJECT_MUL_ARB_PERF_CNT_EN - adds perf_busy_cnt and its counter.
// -----------------------------------------------------------------------------
module myproject_mul_arb_16s_10s
  import myproject_mul_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_STAGE = 2
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  myproject_mul_arb_if.slave  bus
`ifdef MYPROJECT_MUL_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_busy_cnt
`endif
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int SUM_W = ID_W + 1;

  // Pipeline stage registers; index NUM_STAGE-1 drives the response port.
  logic            vld_q [NUM_STAGE];
  logic [ID_W-1:0] id_q  [NUM_STAGE];
  prod_t           p_q   [NUM_STAGE];

  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W-1:0]    last_grant_d;
  logic               advance_s;
  logic               win_found_s;
  logic [ID_W-1:0]    win_id_s;
  logic [SUM_W-1:0]   sum_s;
  logic [SUM_W-1:0]   idx_s;
  logic               xfer_s;
  logic [NUM_REQ-1:0] rdy_s;
  opa_t               a_sel_s;
  opb_t               b_sel_s;
  prod_t              mul_p_s;

  // The pipe moves unless a valid result is blocked by the consumer.
  assign advance_s = ~(vld_q[NUM_STAGE-1] & ~bus.rsp_rdy);

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {ID_W{1'b0}};
    sum_s       = {SUM_W{1'b0}};
    idx_s       = {SUM_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s       = {1'b0, last_grant_q} + SUM_W'(k + 1);
      idx_s       = (sum_s >= SUM_W'(NUM_REQ)) ? (sum_s - SUM_W'(NUM_REQ)) : sum_s;
      win_id_s    = (!win_found_s && bus.req_vld[idx_s[ID_W-1:0]]) ? idx_s[ID_W-1:0] : win_id_s;
      win_found_s = win_found_s | bus.req_vld[idx_s[ID_W-1:0]];
    end
  end

  // A transfer needs a winner, a moving pipe, and reset released.
  assign xfer_s = advance_s & win_found_s & ~ap_rst;

  // One-hot accept toward the winning requester.
  always_comb begin
    rdy_s = {NUM_REQ{1'b0}};
    if (xfer_s) begin
      rdy_s[win_id_s] = 1'b1;
    end else begin
      rdy_s = {NUM_REQ{1'b0}};
    end
  end

  assign bus.req_rdy = rdy_s;

  // AND-OR operand mux driven by the winner index.
  always_comb begin
    a_sel_s = {A_W{1'b0}};
    b_sel_s = {B_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      a_sel_s = a_sel_s | (bus.req_a[A_W*i +: A_W] & {A_W{win_id_s == ID_W'(i)}});
      b_sel_s = b_sel_s | (bus.req_b[B_W*i +: B_W] & {B_W{win_id_s == ID_W'(i)}});
    end
  end

  // Stage-1 arithmetic is the shared combinational multiplier.
  myproject_mul_mul_16s_10s_26_1_1 #(
    .din0_WIDTH (A_W),
    .din1_WIDTH (B_W),
    .dout_WIDTH (P_W)
  ) u_mul (
    .din0 (a_sel_s),
    .din1 (b_sel_s),
    .dout (mul_p_s)
  );

  // Priority pointer only moves on an actual operand transfer.
  assign last_grant_d = xfer_s ? win_id_s : last_grant_q;

  // Arbiter pointer and pipeline stages; everything freezes while stalled.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      for (int s = 0; s < NUM_STAGE; s++) begin
        vld_q[s] <= 1'b0;
        id_q[s]  <= {ID_W{1'b0}};
        p_q[s]   <= {P_W{1'b0}};
      end
    end else if (advance_s) begin
      last_grant_q <= last_grant_d;
      vld_q[0]     <= xfer_s;
      // Bubbles leave the payload untouched; only the valid bit matters.
      if (xfer_s) begin
        id_q[0] <= win_id_s;
        p_q[0]  <= mul_p_s;
      end
      for (int s = 1; s < NUM_STAGE; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
        p_q[s]   <= p_q[s-1];
      end
    end
  end

  assign bus.rsp_vld = vld_q[NUM_STAGE-1];
  assign bus.rsp_id  = id_q[NUM_STAGE-1];
  assign bus.rsp_p   = p_q[NUM_STAGE-1];

`ifdef MYPROJECT_MUL_ARB_PERF_CNT_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] perf_cnt_d;

  // Natural 32-bit wrap from all-ones back to zero.
  assign perf_cnt_d = xfer_s ? (perf_cnt_q + 32'd1) : perf_cnt_q;

  // Transfer-cycle counter.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      perf_cnt_q <= 32'd0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_busy_cnt = perf_cnt_q;
`endif

endmodule

// File: doc/myproject_mul_arb_16s_10s.md
MYPROJECT_MUL_ARB_16S_10S -- requirements
Module: myproject_mul_arb_16s_10s

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the multiplier (2..8).
REQ-002 SHALL have parameter NUM_STAGE, default 2: multiplier pipeline depth in cycles (1..4).
REQ-003 SHALL have port ap_clk, in, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port ap_rst, in, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_vld, in, NUM_REQ: per-requester operand valid.
REQ-006 SHALL have port req_rdy, out, NUM_REQ: per-requester accept; at most one bit is set per cycle.
REQ-007 SHALL have port req_a, in, NUM_REQ*16: packed signed 16-bit multiplicands; requester i uses bits [16*i+15:16*i].
REQ-008 SHALL have port req_b, in, NUM_REQ*10: packed signed 10-bit multipliers; requester i uses bits [10*i+9:10*i].
REQ-009 SHALL have port rsp_vld, out, 1: result valid.
REQ-010 SHALL have port rsp_rdy, in, 1: consumer accept.
REQ-011 SHALL have port rsp_id, out, clog2(NUM_REQ): index of the requester that owns the result.
REQ-012 SHALL have port rsp_p, out, 26: signed product a*b, full precision, no truncation or saturation.

Function
REQ-013 SHALL transfer requester i's operands when req_vld[i] and req_rdy[i] are both high in the same cycle.
REQ-014 SHALL transfer a result when rsp_vld and rsp_rdy are both high in the same cycle.
REQ-015 SHALL define advance = !(rsp_vld && !rsp_rdy); when advance is low, every pipeline stage holds its contents.
REQ-016 SHALL compute req_rdy combinationally: req_rdy[i] = advance && (i is the round-robin winner among the set req_vld bits).
REQ-017 SHALL arbitrate round-robin: the search starts at last_grant+1 modulo NUM_REQ; last_grant updates only when an operand transfer occurs.
REQ-018 SHALL assert no req_rdy bit when req_vld is all-zero; a bubble then enters the pipeline and last_grant is unchanged.
REQ-019 SHALL present an operand pair accepted in cycle t at rsp_p/rsp_id/rsp_vld in cycle t+NUM_STAGE, provided advance stays high throughout.
REQ-020 SHALL delay that result by exactly one cycle for each stall cycle.
REQ-021 SHALL sustain one accepted operand pair per cycle while advance is high.
REQ-022 SHALL hold rsp_vld, rsp_id and rsp_p stable while rsp_vld is high and rsp_rdy is low.
REQ-023 SHALL produce the two's-complement product: -32768 * -512 = +16777216, and 32767 * 511 = 16743937.
REQ-024 SHALL tolerate req_vld being deasserted before its grant; no transfer occurs for that requester.
REQ-025 SHALL keep result order equal to acceptance order.

Reset
REQ-026 SHALL, while ap_rst is high: clear every stage valid bit; hold rsp_vld=0, req_rdy=0, rsp_id=0, rsp_p=0; set last_grant=NUM_REQ-1 so requester 0 has first priority.
REQ-027 SHALL discard any in-flight results when reset is asserted mid-operation; none are emitted after reset release.
REQ-028 SHALL accept requests on the first rising edge after ap_rst deasserts.

Configuration
REQ-029 SHALL, with MYPROJECT_MUL_ARB_PERF_CNT_EN defined, add output perf_busy_cnt (32 bits): counts cycles with an operand transfer, is cleared by ap_rst, and wraps 0xFFFFFFFF -> 0.
REQ-030 SHALL, without MYPROJECT_MUL_ARB_PERF_CNT_EN, contain neither that port nor the counter logic; all other behaviour is identical.

Structure
REQ-031 SHALL place A_W=16, B_W=10, P_W=26 and a clog2 function in the shared package myproject_mul_arb_pkg.
REQ-032 SHALL instantiate the existing combinational multiplier myproject_mul_mul_16s_10s_26_1_1 as its single sub-module in stage 1; stages 2..NUM_STAGE are registers inside this block.

Verification
REQ-033 SHALL cover: reset release, req_vld=0001, a=100, b=-3, rsp_rdy=1 -> rsp_vld in cycle t+2, rsp_id=0, rsp_p=-300.
REQ-034 SHALL cover: req_vld=1111 held for 8 cycles, rsp_rdy=1 -> grants in order 0,1,2,3,0,1,2,3, with one grant per cycle.
REQ-035 SHALL cover: rsp_rdy=0 for 3 cycles while full -> req_rdy=0, and rsp_p/rsp_id are held; after release, results emerge in order with none lost or duplicated.
REQ-036 SHALL cover extreme operands: (-32768,-512) -> 16777216; (32767,-512) -> -16776704; (-32768,511) -> -16744448.
REQ-037 SHALL cover: ap_rst pulsed while 2 results are in flight -> rsp_vld=0 immediately, and no stale result appears after reset.
REQ-038 SHALL cover: with PERF_CNT_EN defined, 5 transfers -> perf_busy_cnt=5; a counter preloaded (forced) to 0xFFFFFFFF plus one transfer -> 0.
